// File: rtl/hvsync_lock_supervisor.sv
// Lock supervisor for the gen_hvconts H/V counter generator: holds it in reset, watches sync
// against hcont/vcont, forces relock on persistent drift. Optional: HVSUP_RELOCK_STATS_EN.
`timescale 1ns/1ps

module hvsync_lock_supervisor #(
    parameter int unsigned MISS_LIMIT    = 3,
    parameter int unsigned STABLE_FRAMES = 4,
    parameter int unsigned RELOCK_HOLD   = 16,
    parameter int unsigned HTOL          = 1,
    parameter int unsigned LOCK_TIMEOUT  = 1048575
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clken,
    input  logic        hs_n,
    input  logic        vs_n,
    input  logic [10:0] hcont,
    input  logic [10:0] vcont,
    input  logic        locked,
    output logic        cnt_reset_n,
    output logic        frame_start,
    output logic        stable,
    output logic [11:0] htotal_meas,
    output logic [11:0] vtotal_meas
`ifdef HVSUP_RELOCK_STATS_EN
    ,
    output logic [7:0]  relock_count
`endif
);

    localparam logic [7:0]  HOLD_INIT = 8'(RELOCK_HOLD);
    localparam logic [19:0] TO_LAST   = 20'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]  MISS_LIM  = 4'(MISS_LIMIT);
    localparam logic [3:0]  STABLE_N  = 4'(STABLE_FRAMES);
    localparam logic [11:0] HTOL_W    = 12'(HTOL);

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_TRACK
    } state_t;

    state_t      state;
    logic [7:0]  hold_cnt;
    logic [19:0] to_cnt;
    logic        hs_prev;
    logic        vs_prev;
    logic [10:0] hc_prev;
    logic [10:0] vc_prev;
    logic [10:0] href;
    logic [10:0] vref;
    logic        href_valid;
    logic        vref_valid;
    logic        skip_first;
    logic        vs_seen;
    logic        frame_bad;
    logic [3:0]  miss;
    logic [3:0]  good;

    logic        posedge_hs;
    logic        posedge_vs;
    logic        fs_tick;
    logic [11:0] h_abs;
    logic [11:0] h_wrap;
    logic [11:0] h_dev;
    logic        hs_mismatch;
    logic        vs_mismatch;
    logic        frame_is_bad;
    logic [3:0]  miss_inc;
    logic [3:0]  good_inc;
    logic        enter_hold;

    always_comb begin
        posedge_hs = clken & ~hs_prev & hs_n;
        posedge_vs = clken & ~vs_prev & vs_n;
        fs_tick    = (state == S_TRACK) && clken && (hcont == '0) && (vcont == '0);
    end

    // hs phase error is taken modulo the measured line length so a reference near the
    // line wrap does not look like a full-line error.
    always_comb begin
        h_abs  = '0;
        h_wrap = '0;
        if (hcont >= href)
            h_abs = {1'b0, hcont} - {1'b0, href};
        else
            h_abs = {1'b0, href} - {1'b0, hcont};
        h_wrap = htotal_meas - h_abs;
        h_dev  = h_abs;
        if ((htotal_meas != '0) && (h_abs < htotal_meas) && (h_wrap < h_abs))
            h_dev = h_wrap;
    end

    always_comb begin
        hs_mismatch  = posedge_hs && href_valid && (h_dev > HTOL_W);
        vs_mismatch  = posedge_vs && vref_valid && (vcont != vref);
        frame_is_bad = frame_bad || hs_mismatch || vs_mismatch || (!skip_first && !vs_seen);
        miss_inc     = (miss == 4'hF) ? miss : miss + 4'd1;
        good_inc     = (good == 4'hF) ? good : good + 4'd1;
    end

    always_comb begin
        enter_hold = 1'b0;
        if ((state == S_WAIT_LOCK) && !locked && clken && (to_cnt == TO_LAST))
            enter_hold = 1'b1;
        if ((state == S_TRACK) && !locked)
            enter_hold = 1'b1;
        if (fs_tick && !skip_first && frame_is_bad && (miss_inc == MISS_LIM))
            enter_hold = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_HOLD;
            hold_cnt    <= HOLD_INIT;
            to_cnt      <= '0;
            cnt_reset_n <= 1'b0;
            frame_start <= 1'b0;
            stable      <= 1'b0;
            htotal_meas <= '0;
            vtotal_meas <= '0;
            hs_prev     <= 1'b1;
            vs_prev     <= 1'b1;
            hc_prev     <= '0;
            vc_prev     <= '0;
            href        <= '0;
            vref        <= '0;
            href_valid  <= 1'b0;
            vref_valid  <= 1'b0;
            skip_first  <= 1'b0;
            vs_seen     <= 1'b0;
            frame_bad   <= 1'b0;
            miss        <= '0;
            good        <= '0;
        end else begin
            frame_start <= 1'b0;
            if (clken) begin
                hs_prev <= hs_n;
                vs_prev <= vs_n;
                hc_prev <= hcont;
                vc_prev <= vcont;
            end

            unique case (state)
                S_HOLD: begin
                    hold_cnt <= hold_cnt - 8'd1;
                    if (hold_cnt == 8'd1) begin
                        cnt_reset_n <= 1'b1;
                        to_cnt      <= '0;
                        state       <= S_WAIT_LOCK;
                    end
                end

                S_WAIT_LOCK: begin
                    if (locked) begin
                        miss       <= '0;
                        good       <= '0;
                        href_valid <= 1'b0;
                        vref_valid <= 1'b0;
                        skip_first <= 1'b1;
                        vs_seen    <= 1'b0;
                        frame_bad  <= 1'b0;
                        state      <= S_TRACK;
                    end else if (clken) begin
                        to_cnt <= to_cnt + 20'd1;
                    end
                end

                S_TRACK: begin
                    if (locked && clken) begin
                        if (posedge_hs && !href_valid) begin
                            href       <= hcont;
                            href_valid <= 1'b1;
                        end
                        if (posedge_vs && !vref_valid) begin
                            vref       <= vcont;
                            vref_valid <= 1'b1;
                        end
                        if ((hcont == '0) && (hc_prev != '0))
                            htotal_meas <= {1'b0, hc_prev} + 12'd1;
                        if ((vcont == '0) && (vc_prev != '0))
                            vtotal_meas <= {1'b0, vc_prev} + 12'd1;

                        // Errors seen on the frame_start tick itself are folded into
                        // frame_is_bad, so they close out the finishing frame.
                        if (fs_tick) begin
                            frame_start <= 1'b1;
                            vs_seen     <= posedge_vs;
                            frame_bad   <= 1'b0;
                            if (skip_first) begin
                                skip_first <= 1'b0;
                            end else if (frame_is_bad) begin
                                miss   <= miss_inc;
                                good   <= '0;
                                stable <= 1'b0;
                            end else begin
                                miss <= '0;
                                good <= good_inc;
                                if (good_inc >= STABLE_N)
                                    stable <= 1'b1;
                            end
                        end else begin
                            if (posedge_vs)
                                vs_seen <= 1'b1;
                            if (hs_mismatch || vs_mismatch)
                                frame_bad <= 1'b1;
                        end
                    end
                end

                default: state <= S_HOLD;
            endcase

            if (enter_hold) begin
                state       <= S_HOLD;
                hold_cnt    <= HOLD_INIT;
                cnt_reset_n <= 1'b0;
                stable      <= 1'b0;
            end
        end
    end

`ifdef HVSUP_RELOCK_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            relock_count <= '0;
        else if (enter_hold && (relock_count != 8'hFF))
            relock_count <= relock_count + 8'd1;
    end
`endif

endmodule
